// File: rtl/toy_pkg.sv
// toy_pkg: shared constants and one-hot state type
// for the toy processor instruction-cycle sequencer.
package toy_pkg;

  localparam int NUM_STATES = 6;

  localparam int ST_FETCH  = 0;
  localparam int ST_DECODE = 1;
  localparam int ST_EXEC   = 2;
  localparam int ST_MEM    = 3;
  localparam int ST_WB     = 4;
  localparam int ST_HALT   = 5;

  typedef enum logic [NUM_STATES-1:0] {
    S_FETCH  = 6'b000001,
    S_DECODE = 6'b000010,
    S_EXEC   = 6'b000100,
    S_MEM    = 6'b001000,
    S_WB     = 6'b010000,
    S_HALT   = 6'b100000
  } state_t;

endpackage

// File: rtl/toy_wait_timer.sv
// toy_wait_timer: counts consecutive not-ready memory
// cycles and flags the last tolerated one.
module toy_wait_timer #(
  parameter int WAIT_MAX = 7
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic inc_i,
  output logic expire_o
);

  localparam int CW =
    (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;
  localparam logic [CW-1:0] LIM = CW'(WAIT_MAX - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (WAIT_MAX > 0) && (cnt_q == LIM);

endmodule

// File: rtl/toy_cycle_ctrl.sv
// toy_cycle_ctrl: one-hot instruction-cycle sequencer
// owning PC, IR, memory strobes and single-step control.
module toy_cycle_ctrl
  import toy_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter int                DATA_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                WAIT_MAX = 7
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic [DATA_W-1:0]     D_IN,
  input  logic                  MEM_READY,
  input  logic                  OP_IS_HALT,
  input  logic                  OP_IS_JMP,
  input  logic                  OP_IS_MEM,
  input  logic                  OP_IS_STORE,
  input  logic [ADDR_W-1:0]     JMP_ADDR,
  input  logic                  STEP_MODE,
  input  logic                  STEP,
  output logic [NUM_STATES-1:0] S,
  output logic [ADDR_W-1:0]     PC,
  output logic [DATA_W-1:0]     IR,
  output logic                  MEM_EN,
  output logic                  WRITE_EN,
  output logic                  MEM_SEL,
  output logic                  INSTR_DONE,
  output logic                  TIMEOUT
);

  state_t            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [DATA_W-1:0] ir_q;
  logic              tmo_q;
  logic              done_q;
  logic              access;
  logic              wt_clr;
  logic              wt_inc;
  logic              expire;

  assign access = state_q[ST_FETCH] | state_q[ST_MEM];
  assign wt_clr = ~access | MEM_READY;
  assign wt_inc = access & ~MEM_READY;

  toy_wait_timer #(
    .WAIT_MAX(WAIT_MAX)
  ) u_wait (
    .clk_i   (CLK),
    .rst_ni  (RESET_N),
    .clr_i   (wt_clr),
    .inc_i   (wt_inc),
    .expire_o(expire)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      tmo_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (1'b1)
        state_q[ST_FETCH]: begin
          if (MEM_READY) begin
            ir_q    <= D_IN;
            pc_q    <= pc_q + ADDR_W'(1);
            state_q <= S_DECODE;
          end else if (expire) begin
            state_q <= S_HALT;
            tmo_q   <= 1'b1;
          end
        end
        state_q[ST_DECODE]: begin
          state_q <= OP_IS_HALT ? S_HALT : S_EXEC;
        end
        state_q[ST_EXEC]: begin
          if (OP_IS_JMP) begin
            pc_q    <= JMP_ADDR;
            state_q <= S_WB;
            done_q  <= 1'b1;
          end else if (OP_IS_MEM) begin
            state_q <= S_MEM;
          end else begin
            state_q <= S_WB;
            done_q  <= 1'b1;
          end
        end
        state_q[ST_MEM]: begin
          if (MEM_READY) begin
            state_q <= S_WB;
            done_q  <= 1'b1;
          end else if (expire) begin
            state_q <= S_HALT;
            tmo_q   <= 1'b1;
          end
        end
        // step mode parks here until STEP is seen high
        state_q[ST_WB]: begin
          if (!STEP_MODE || STEP) begin
            state_q <= S_FETCH;
          end
        end
        state_q[ST_HALT]: begin
          state_q <= S_HALT;
        end
        default: begin
          state_q <= S_HALT;
        end
      endcase
    end
  end

  assign S          = state_q;
  assign PC         = pc_q;
  assign IR         = ir_q;
  assign TIMEOUT    = tmo_q;
  assign MEM_EN     = RESET_N & access;
  assign MEM_SEL    = RESET_N & state_q[ST_MEM];
  assign WRITE_EN   = RESET_N & state_q[ST_MEM] & OP_IS_STORE;
  assign INSTR_DONE = RESET_N & done_q;

endmodule

// File: tb/tb_toy_cycle_ctrl.sv
// tb_toy_cycle_ctrl: directed and random checks of the
// cycle sequencer against an instruction-level model.
module tb_toy_cycle_ctrl;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int WM = 3;
  localparam logic [AW-1:0] RPC = 8'h10;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] din   = '0;
  logic          rdy   = 1'b0;
  logic          halt  = 1'b0;
  logic          jmp   = 1'b0;
  logic          mem   = 1'b0;
  logic          store = 1'b0;
  logic [AW-1:0] jaddr = '0;
  logic          smode = 1'b0;
  logic          step  = 1'b0;

  logic [5:0]    s;
  logic [AW-1:0] pc;
  logic [DW-1:0] ir;
  logic          men, wen, msel, idone, tmo;

  int n_chk  = 0;
  int n_pass = 0;

  // model: phase 0..5 = fetch,decode,exec,mem,wb,halt
  int            m_ph;
  int            m_waits;
  logic [AW-1:0] m_pc;
  logic [DW-1:0] m_ir;
  logic          m_tmo;
  logic          m_first;

  always #5 clk = ~clk;

  toy_cycle_ctrl #(
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .RESET_PC(RPC),
    .WAIT_MAX(WM)
  ) dut (
    .CLK        (clk),
    .RESET_N    (rst_n),
    .D_IN       (din),
    .MEM_READY  (rdy),
    .OP_IS_HALT (halt),
    .OP_IS_JMP  (jmp),
    .OP_IS_MEM  (mem),
    .OP_IS_STORE(store),
    .JMP_ADDR   (jaddr),
    .STEP_MODE  (smode),
    .STEP       (step),
    .S          (s),
    .PC         (pc),
    .IR         (ir),
    .MEM_EN     (men),
    .WRITE_EN   (wen),
    .MEM_SEL    (msel),
    .INSTR_DONE (idone),
    .TIMEOUT    (tmo)
  );

  task automatic check(input string nm,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h at %0t",
                  nm, got, exp, $time);
  endtask

  function automatic void m_reset();
    m_ph    = 0;
    m_waits = 0;
    m_pc    = RPC;
    m_ir    = '0;
    m_tmo   = 1'b0;
    m_first = 1'b0;
  endfunction

  // one memory access may see WM not-ready cycles at most
  function automatic void m_wait_or_halt();
    if (WM > 0 && m_waits + 1 == WM) begin
      m_ph  = 5;
      m_tmo = 1'b1;
    end else begin
      m_waits++;
    end
  endfunction

  function automatic void m_step();
    if (!rst_n) begin
      m_reset();
      return;
    end
    m_first = 1'b0;
    case (m_ph)
      0: if (rdy) begin
           m_ir    = din;
           m_pc    = m_pc + 8'd1;
           m_ph    = 1;
           m_waits = 0;
         end else m_wait_or_halt();
      1: m_ph = halt ? 5 : 2;
      2: if (jmp) begin
           m_pc = jaddr; m_ph = 4; m_first = 1'b1;
         end else if (mem) begin
           m_ph = 3; m_waits = 0;
         end else begin
           m_ph = 4; m_first = 1'b1;
         end
      3: if (rdy) begin
           m_ph = 4; m_first = 1'b1;
         end else m_wait_or_halt();
      4: if (!smode || step) begin
           m_ph = 0; m_waits = 0;
         end
      default: ;
    endcase
  endfunction

  task automatic cmp();
    logic a;
    if (!rst_n) m_reset();
    a = rst_n;
    check("S", 32'(s), 32'(1) << m_ph);
    check("PC", 32'(pc), 32'(m_pc));
    check("IR", 32'(ir), 32'(m_ir));
    check("MEM_EN", 32'(men),
          32'(a && (m_ph == 0 || m_ph == 3)));
    check("MEM_SEL", 32'(msel), 32'(a && m_ph == 3));
    check("WRITE_EN", 32'(wen),
          32'(a && m_ph == 3 && store));
    check("INSTR_DONE", 32'(idone),
          32'(a && m_ph == 4 && m_first));
    check("TIMEOUT", 32'(tmo), 32'(m_tmo));
  endtask

  task automatic cyc();
    @(posedge clk);
    m_step();
    @(negedge clk);
    cmp();
  endtask

  initial begin
    int dn;
    int mc;
    int n;
    m_reset();
    repeat (2) @(negedge clk);
    cmp();
    check("rst_S", 32'(s), 32'h01);
    check("rst_PC", 32'(pc), 32'h10);
    check("rst_IR", 32'(ir), 32'h00);
    check("rst_MEM_EN", 32'(men), 32'h0);
    check("rst_TIMEOUT", 32'(tmo), 32'h0);

    din = 8'hA5; rdy = 1'b1; rst_n = 1'b1;
    #1 check("t1_MEM_EN", 32'(men), 32'h1);
    cyc();
    check("t1_S_dec", 32'(s), 32'h02);
    check("t1_PC", 32'(pc), 32'h11);
    check("t1_IR", 32'(ir), 32'hA5);
    cyc();
    check("t1_S_exe", 32'(s), 32'h04);
    cyc();
    check("t1_S_wb", 32'(s), 32'h10);
    check("t1_done", 32'(idone), 32'h1);
    cyc();
    check("t1_S_fetch", 32'(s), 32'h01);
    dn = 0;
    repeat (8) begin cyc(); dn += int'(idone); end
    check("t1_done_cnt", 32'(dn), 32'd2);

    mem = 1'b1; store = 1'b1; mc = 0; n = 0;
    for (int i = 0; i < 20; i++) begin
      if (n > 0 && s == 6'h01) break;
      rdy = (s == 6'h08) ? (mc >= 2) : 1'b1;
      if (men && wen && msel) mc++;
      cyc();
      n++;
    end
    check("st_strobe_cyc", 32'(mc), 32'd3);
    check("st_instr_cyc", 32'(n), 32'd7);
    mem = 1'b0; store = 1'b0; din = 8'h00; rdy = 1'b1;

    jmp = 1'b1; jaddr = 8'hFF;
    repeat (4) cyc();
    check("j_S_ff", 32'(s), 32'h01);
    check("j_PC_ff", 32'(pc), 32'hFF);
    jaddr = 8'h40;
    cyc();
    check("j_PC_wrap", 32'(pc), 32'h00);
    cyc(); cyc();
    check("j_S_wb", 32'(s), 32'h10);
    check("j_PC_tgt", 32'(pc), 32'h40);
    cyc();
    check("j_S_fetch", 32'(s), 32'h01);
    check("j_PC_fetch", 32'(pc), 32'h40);
    check("j_MEM_SEL", 32'(msel), 32'h0);
    jmp = 1'b0;

    smode = 1'b1; step = 1'b0; dn = 0;
    repeat (14) begin cyc(); dn += int'(idone); end
    check("sm_hold_S", 32'(s), 32'h10);
    check("sm_done1", 32'(dn), 32'd1);
    step = 1'b1;
    cyc();
    step = 1'b0; dn = 0;
    repeat (10) begin cyc(); dn += int'(idone); end
    check("sm_done2", 32'(dn), 32'd1);
    check("sm_hold_S2", 32'(s), 32'h10);
    smode = 1'b0;
    cyc();
    check("sm_exit_S", 32'(s), 32'h01);

    rdy = 1'b0;
    cyc(); cyc();
    check("to_wait_S", 32'(s), 32'h01);
    check("to_wait_T", 32'(tmo), 32'h0);
    cyc();
    check("to_halt_S", 32'(s), 32'h20);
    check("to_halt_T", 32'(tmo), 32'h1);
    rdy = 1'b1;
    repeat (3) cyc();
    check("to_stay_S", 32'(s), 32'h20);

    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1; rdy = 1'b0;
    cyc(); cyc();
    rdy = 1'b1;
    cyc();
    check("to_late_S", 32'(s), 32'h02);
    check("to_late_T", 32'(tmo), 32'h0);

    mem = 1'b1; store = 1'b1; rdy = 1'b0;
    cyc(); cyc();
    check("ar_we_hi", 32'(wen), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_we_lo", 32'(wen), 32'h0);
    check("ar_men_lo", 32'(men), 32'h0);
    check("ar_S", 32'(s), 32'h01);
    check("ar_PC", 32'(pc), 32'h10);
    check("ar_T", 32'(tmo), 32'h0);
    m_reset();
    cyc();
    rst_n = 1'b1; mem = 1'b0; store = 1'b0;

    for (int i = 0; i < 4000; i++) begin
      if (m_ph == 5 && ($urandom % 4) == 0) begin
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
      end
      din   = 8'($urandom);
      jaddr = 8'($urandom);
      rdy   = ($urandom % 10) < 7;
      halt  = ($urandom % 40) == 0;
      jmp   = ($urandom % 4) == 0;
      mem   = ($urandom % 5) < 2;
      store = ($urandom % 2) == 0;
      if (($urandom % 50) == 0) smode = ~smode;
      step  = ($urandom % 3) == 0;
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
